// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing with branch redirect, stall hold and
// pending-redirect capture, driving a read-only instruction SRAM port.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    output logic        fetch_addr_err,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   pc_q;
    logic            ce_q;
    logic            pend_valid_q;
    logic [AW-1:0]   pend_addr_q;
    logic [AW-1:0]   fetch_count_q;

    logic            br_e;
    logic [AW-1:0]   br_addr;
    logic            stall_here;
    logic [AW-1:0]   pc_d;
    logic            unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign stall_here   = stall[0];
    assign unused_stall = ^stall[5:1];

    // Live redirect beats a pending one, which beats sequential fetch.
    always_comb begin
        pc_d = pc_q + AW'(4);
        if (br_e) begin
            pc_d = br_addr;
        end else if (pend_valid_q) begin
            pc_d = pend_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RESET;
            pc_q          <= RESET_PC;
            ce_q          <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            fetch_count_q <= '0;
        end else begin
            if (ce_q && !stall_here) begin
                fetch_count_q <= fetch_count_q + AW'(1);
            end
            case (state_q)
                S_RESET, S_RUN: begin
                    if (stall_here) begin
                        state_q <= S_HOLD;
                    end else begin
                        state_q      <= S_RUN;
                        pc_q         <= pc_d;
                        ce_q         <= 1'b1;
                        pend_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (stall_here) begin
                        // Latest redirect seen during the hold wins.
                        if (br_e) begin
                            pend_addr_q  <= br_addr;
                            pend_valid_q <= 1'b1;
                        end
                    end else begin
                        state_q      <= S_RUN;
                        pc_q         <= pc_d;
                        ce_q         <= 1'b1;
                        pend_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_RESET;
                end
            endcase
        end
    end

    assign fetch_addr_err  = ce_q & (pc_q[1:0] != 2'b00);
    assign inst_sram_en    = ce_q & ~fetch_addr_err;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign if_to_id_bus    = {ce_q, pc_q};
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, redirects, stalls,
// pending-redirect handling, misalignment, PC wrap and reset mid-hold.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        fetch_addr_err;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .if_to_id_bus   (if_to_id_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .fetch_addr_err (fetch_addr_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full view of one fetch slot against hand-computed values.
    task automatic slot(input string tag, input logic ce, input logic [31:0] pc,
                        input logic [31:0] cnt, input logic en, input logic err);
        check({tag, ".bus"},  if_to_id_bus, {ce, pc});
        check({tag, ".addr"}, 33'(inst_sram_addr), 33'(pc));
        check({tag, ".cnt"},  33'(fetch_count), 33'(cnt));
        check({tag, ".en"},   33'(inst_sram_en), 33'(en));
        check({tag, ".err"},  33'(fetch_addr_err), 33'(err));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        stall    = 6'b0;
        br_bus   = 33'h0;

        step();
        step();
        slot("reset", 1'b0, 32'hBFBF_FFFC, 32'd0, 1'b0, 1'b0);
        check("wen",   33'(inst_sram_wen), 33'h0);
        check("wdata", 33'(inst_sram_wdata), 33'h0);

        // Sequential fetch after reset release
        rst = 1'b0;
        step(); slot("seq0", 1'b1, 32'hBFC0_0000, 32'd0, 1'b1, 1'b0);
        step(); slot("seq1", 1'b1, 32'hBFC0_0004, 32'd1, 1'b1, 1'b0);
        stall = 6'b111110;
        step(); slot("seq2", 1'b1, 32'hBFC0_0008, 32'd2, 1'b1, 1'b0);
        stall = 6'b0;

        // One-cycle redirect in run
        br_bus = {1'b1, 32'hBFC0_0100};
        step(); slot("br_run", 1'b1, 32'hBFC0_0100, 32'd3, 1'b1, 1'b0);
        br_bus = 33'h0;
        step(); slot("br_run_nxt", 1'b1, 32'hBFC0_0104, 32'd4, 1'b1, 1'b0);
        br_bus = {1'b1, 32'hBFC0_0010};
        step(); slot("to_10", 1'b1, 32'hBFC0_0010, 32'd5, 1'b1, 1'b0);
        br_bus = 33'h0;

        // Three-cycle stall, redirect captured in the 2nd stall cycle
        stall = 6'b000001;
        step(); slot("st1", 1'b1, 32'hBFC0_0010, 32'd5, 1'b1, 1'b0);
        br_bus = {1'b1, 32'hBFC0_0200};
        step(); slot("st2", 1'b1, 32'hBFC0_0010, 32'd5, 1'b1, 1'b0);
        br_bus = 33'h0;
        step(); slot("st3", 1'b1, 32'hBFC0_0010, 32'd5, 1'b1, 1'b0);
        stall = 6'b0;
        step(); slot("pend_use", 1'b1, 32'hBFC0_0200, 32'd6, 1'b1, 1'b0);
        step(); slot("pend_once", 1'b1, 32'hBFC0_0204, 32'd7, 1'b1, 1'b0);

        // Live redirect in release cycle beats pending
        stall = 6'b000001;
        step(); slot("h1", 1'b1, 32'hBFC0_0204, 32'd7, 1'b1, 1'b0);
        br_bus = {1'b1, 32'hBFC0_0300};
        step(); slot("h2", 1'b1, 32'hBFC0_0204, 32'd7, 1'b1, 1'b0);
        stall  = 6'b0;
        br_bus = {1'b1, 32'hBFC0_0400};
        step(); slot("live_wins", 1'b1, 32'hBFC0_0400, 32'd8, 1'b1, 1'b0);
        br_bus = 33'h0;
        step(); slot("live_nxt", 1'b1, 32'hBFC0_0404, 32'd9, 1'b1, 1'b0);

        // Misaligned target keeps advancing with enable suppressed
        br_bus = {1'b1, 32'hBFC0_0002};
        step(); slot("mis0", 1'b1, 32'hBFC0_0002, 32'd10, 1'b0, 1'b1);
        br_bus = 33'h0;
        step(); slot("mis1", 1'b1, 32'hBFC0_0006, 32'd11, 1'b0, 1'b1);

        // PC wrap at top of address space
        br_bus = {1'b1, 32'hFFFF_FFFC};
        step(); slot("top", 1'b1, 32'hFFFF_FFFC, 32'd12, 1'b1, 1'b0);
        br_bus = 33'h0;
        step(); slot("wrap", 1'b1, 32'h0000_0000, 32'd13, 1'b1, 1'b0);

        // Reset during hold discards pending redirect
        stall = 6'b000001;
        step(); slot("rh1", 1'b1, 32'h0000_0000, 32'd13, 1'b1, 1'b0);
        br_bus = {1'b1, 32'hBFC0_0500};
        step(); slot("rh2", 1'b1, 32'h0000_0000, 32'd13, 1'b1, 1'b0);
        br_bus = 33'h0;
        rst    = 1'b1;
        step(); slot("rh_rst", 1'b0, 32'hBFBF_FFFC, 32'd0, 1'b0, 1'b0);
        rst   = 1'b0;
        stall = 6'b0;
        step(); slot("rh_rel0", 1'b1, 32'hBFC0_0000, 32'd0, 1'b1, 1'b0);
        step(); slot("rh_rel1", 1'b1, 32'hBFC0_0004, 32'd1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hBFBF_FFFC, is the PC value held during reset; the first fetched address is RESET_PC+4 = 32'hBFC0_0000.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  6  pipeline stall vector; stall[0]=1 freezes this stage.
REQ-005 br_bus  input  33  {br_e[32], br_addr[31:0]}; redirect request from decode.
REQ-006 if_to_id_bus  output  33  {ce[32], pc[31:0]}; fetch slot handed to decode.
REQ-007 inst_sram_en  output  1  instruction memory read enable.
REQ-008 inst_sram_wen  output  4  byte write enables; constant 4'b0000.
REQ-009 inst_sram_addr  output  32  fetch address.
REQ-010 inst_sram_wdata  output  32  write data; constant 32'h0.
REQ-011 fetch_addr_err  output  1  current fetch address misaligned.
REQ-012 fetch_count  output  32  number of fetch slots issued.

Function
REQ-013 State register pc_reg[31:0], ce_reg, pend_valid, pend_addr[31:0], fetch_count, and a 2-bit FSM: S_RESET, S_RUN, S_HOLD.
REQ-014 if_to_id_bus = {ce_reg, pc_reg}; inst_sram_addr = pc_reg; inst_sram_en = ce_reg & ~fetch_addr_err; all outputs are combinational from registers, with no input-to-output path except through registers.
REQ-015 fetch_addr_err = ce_reg & (pc_reg[1:0] != 2'b00).
REQ-016 The next-PC select has the following priority:
- live br_e=1 -> br_addr
- else pend_valid=1 -> pend_addr
- else pc_reg + 32'h4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 S_RESET is the state during rst; it is left on the first cycle with rst=0: ce_reg<=1, pc_reg<=next-PC, and the FSM goes to S_RUN (or S_HOLD if stall[0]=1, with pc_reg/ce_reg unchanged).
REQ-018 In S_RUN with stall[0]=0: pc_reg<=next-PC, ce_reg stays 1, and pend_valid<=0 in the same cycle.
REQ-019 When stall[0]=1 in any non-reset state: pc_reg and ce_reg hold, and the FSM goes to S_HOLD.
REQ-020 In S_HOLD, br_e=1 captures pend_addr<=br_addr and pend_valid<=1; a later br_e during the same hold overwrites pend_addr (latest wins).
REQ-021 In S_HOLD, a cycle with stall[0]=0 advances pc_reg per REQ-016 (a live br_e beats pending), clears pend_valid, and returns to S_RUN.
REQ-022 A redirect is consumed exactly once: after a pending target is used, subsequent advances are sequential (+4).
REQ-023 br_e=1 in S_RUN with stall[0]=0 redirects in one cycle: pc_reg equals br_addr on the following edge, and nothing is written to pending.
REQ-024 fetch_count increments by 1 on every edge where ce_reg=1, stall[0]=0 and rst=0; it wraps 32'hFFFF_FFFF -> 0.
REQ-025 A misaligned pc_reg does not stall the stage: it advances normally, en is suppressed, and fetch_addr_err stays high for the cycles pc_reg is misaligned.

Reset
REQ-026 On rst=1 at a posedge, regardless of state or pending redirect:
- pc_reg<=RESET_PC, ce_reg<=0, pend_valid<=0, pend_addr<=0, fetch_count<=0, FSM<=S_RESET.
REQ-027 While in reset, outputs are if_to_id_bus={1'b0, RESET_PC}, inst_sram_en=0, fetch_addr_err=0, fetch_count=0.
REQ-028 rst asserted mid-hold discards the pending redirect; the first post-reset fetch is 32'hBFC0_0000.

Verification
REQ-029 Reset release, stall=0, br_e=0 for 4 cycles -> pc sequence BFC0_0000, BFC0_0004, BFC0_0008, BFC0_000C; ce=1; en=1; fetch_count 0,1,2,3.
REQ-030 At pc=BFC0_0008, br_bus={1, 32'hBFC0_0100}, stall=0 -> next pc=BFC0_0100, then BFC0_0104; pend_valid stays 0.
REQ-031 stall[0]=1 for 3 cycles at pc=BFC0_0010, br_e=1 with BFC0_0200 in the 2nd stall cycle only, then stall released -> pc holds BFC0_0010 during the stall, then BFC0_0200, then BFC0_0204; fetch_count frozen during the stall.
REQ-032 During a hold, pending=BFC0_0300, then live br_e=1 with BFC0_0400 in the release cycle -> pc=BFC0_0400, next BFC0_0404, pend_valid=0.
REQ-033 br_e=1 with br_addr=32'hBFC0_0002 -> fetch_addr_err=1 and inst_sram_en=0 for that slot; the next pc is BFC0_0006 and the error remains 1.
REQ-034 rst=1 while pend_valid=1 with target BFC0_0500, then released -> first pc BFC0_0000, no jump to BFC0_0500; fetch_count=0.
